// File: rtl/pdp8_ram_pkg.sv
// Constants and FSM state type for the PDP-8 SRAM controller.
`timescale 1ns/1ps
package pdp8_ram_pkg;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 12;
  localparam int SRAM_A_W = 18;
  localparam int SRAM_D_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WPULSE = 2'd1,
    WHOLD  = 2'd2
  } wr_state_e;
endpackage

// File: rtl/sram_io_buf.sv
// Tri-state driver and read-back for one bidirectional SRAM data bus.
`timescale 1ns/1ps
module sram_io_buf #(
  parameter int W = 16
) (
  inout  wire  [W-1:0] sram_io,
  input  logic         drive_en_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o
);
  assign sram_io = drive_en_i ? wdata_i : {W{1'bz}};
  assign rdata_o = sram_io;
endmodule

// File: rtl/pdp8_ram_ctrl.sv
// PDP-8 word memory on an async 16-bit SRAM (chip 1 only; chip 2 parked).
// Define SRAM_READ_LATCH_EN for a registered data_out with one-clock read latency.
`timescale 1ns/1ps
module pdp8_ram_ctrl #(
  parameter int ADDR_W = pdp8_ram_pkg::ADDR_W,
  parameter int DATA_W = pdp8_ram_pkg::DATA_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [DATA_W-1:0]                 data_in,
  output logic [DATA_W-1:0]                 data_out,
  input  logic                              rd,
  input  logic                              wr,
  output logic [pdp8_ram_pkg::SRAM_A_W-1:0] sram_a,
  output logic                              sram_oe_n,
  output logic                              sram_we_n,
  inout  wire  [pdp8_ram_pkg::SRAM_D_W-1:0] sram1_io,
  output logic                              sram1_ce_n,
  output logic                              sram1_ub_n,
  output logic                              sram1_lb_n,
  inout  wire  [pdp8_ram_pkg::SRAM_D_W-1:0] sram2_io,
  output logic                              sram2_ce_n,
  output logic                              sram2_ub_n,
  output logic                              sram2_lb_n
);
  import pdp8_ram_pkg::*;

  wr_state_e           state_q;
  logic                we_n_q;
  logic                drive_q;
  logic                rd_ok;
  logic [SRAM_D_W-1:0] rd_bus;
  logic [SRAM_D_W-1:0] wr_bus;
  logic [DATA_W-1:0]   rd_data_q;
  logic                unused_bits;

  assign sram_a = {{(SRAM_A_W-ADDR_W){1'b0}}, addr};
  assign wr_bus = {{(SRAM_D_W-DATA_W){1'b0}}, data_in};

  // One WE pulse per wr assertion; the bus stays driven through WHOLD so data
  // is still valid when WE rises at the end of the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr) begin
            state_q <= WPULSE;
            we_n_q  <= 1'b0;
            drive_q <= 1'b1;
          end
        end
        WPULSE: begin
          state_q <= WHOLD;
          we_n_q  <= 1'b1;
        end
        WHOLD: begin
          if (!wr) begin
            state_q <= IDLE;
            drive_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          we_n_q  <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  // OE only in IDLE, where drive_q is always clear, so the buses never fight.
  assign rd_ok     = reset & rd & ~wr & (state_q == IDLE);
  assign sram_oe_n = ~rd_ok;
  assign sram_we_n = we_n_q;

  sram_io_buf #(.W(SRAM_D_W)) u_sram1 (
    .sram_io    (sram1_io),
    .drive_en_i (drive_q),
    .wdata_i    (wr_bus),
    .rdata_o    (rd_bus)
  );

`ifdef SRAM_READ_LATCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_ok) begin
      rd_data_q <= rd_bus[DATA_W-1:0];
    end
  end

  assign data_out = rd_data_q;
`else
  // Remembers the last word read so data_out holds once rd drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_ok) begin
      rd_data_q <= rd_bus[DATA_W-1:0];
    end
  end

  assign data_out = !reset ? '0 : (rd ? rd_bus[DATA_W-1:0] : rd_data_q);
`endif

  assign unused_bits = &{1'b0, rd_bus[SRAM_D_W-1:DATA_W]};

  assign sram1_ce_n = ~reset;
  assign sram1_ub_n = ~reset;
  assign sram1_lb_n = ~reset;

  assign sram2_ce_n = 1'b1;
  assign sram2_ub_n = 1'b1;
  assign sram2_lb_n = 1'b1;
  assign sram2_io   = {SRAM_D_W{1'bz}};
endmodule

// File: tb/tb_pdp8_ram_ctrl.sv
// Directed bench for pdp8_ram_ctrl with a behavioural async SRAM on chip 1.
`timescale 1ns/1ps
module tb_pdp8_ram_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addr;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        rd;
  logic        wr;
  logic [17:0] sram_a;
  logic        sram_oe_n;
  logic        sram_we_n;
  wire  [15:0] sram1_io;
  logic        sram1_ce_n;
  logic        sram1_ub_n;
  logic        sram1_lb_n;
  wire  [15:0] sram2_io;
  logic        sram2_ce_n;
  logic        sram2_ub_n;
  logic        sram2_lb_n;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int low_cnt = 0;
  int sram2_bad = 0;
  int p0;
  wire unused_tb = &{1'b0, sram2_io};

  always #5 clk = ~clk;

  pdp8_ram_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd         (rd),
    .wr         (wr),
    .sram_a     (sram_a),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram1_io   (sram1_io),
    .sram1_ce_n (sram1_ce_n),
    .sram1_ub_n (sram1_ub_n),
    .sram1_lb_n (sram1_lb_n),
    .sram2_io   (sram2_io),
    .sram2_ce_n (sram2_ce_n),
    .sram2_ub_n (sram2_ub_n),
    .sram2_lb_n (sram2_lb_n)
  );

  // Async SRAM model: drives on OE, latches on the rising edge of WE.
  logic [15:0] mem [0:32767];
  assign sram1_io = (!sram1_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a[14:0]] : 16'bz;
  always @(posedge sram_we_n) if (!sram1_ce_n) mem[sram_a[14:0]] <= sram1_io;

  always @(negedge sram_we_n) pulse_cnt <= pulse_cnt + 1;
  always @(negedge clk) begin
    if (!sram_we_n) low_cnt <= low_cnt + 1;
    if (!(sram2_ce_n && sram2_ub_n && sram2_lb_n)) sram2_bad <= sram2_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [11:0] d, input int hold);
    int pw;
    int lw;
    @(negedge clk);
    pw = pulse_cnt;
    lw = low_cnt;
    addr = a;
    data_in = d;
    wr = 1'b1;
    #1;
    check_eq("wr_sram_a", 32'(sram_a), 32'({3'b000, a}));
    repeat (hold) @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check_eq("wr_pulses", pulse_cnt - pw, 1);
    check_eq("wr_low_clks", low_cnt - lw, 1);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [11:0] exp, input string tag);
    @(negedge clk);
    addr = a;
    rd = 1'b1;
`ifdef SRAM_READ_LATCH_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check_eq(tag, 32'(data_out), 32'(exp));
    check_eq({tag, "_oe_n"}, 32'(sram_oe_n), 0);
    @(negedge clk);
    rd = 1'b0;
    #1;
    check_eq({tag, "_hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    #1 reset = 1'b0;
    rd = 1'b1;
    #1;
    check_eq("rst_we_n", 32'(sram_we_n), 1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 1);
    check_eq("rst_ce1_n", 32'(sram1_ce_n), 1);
    check_eq("rst_ub1_n", 32'(sram1_ub_n), 1);
    check_eq("rst_drive", 32'(dut.drive_q), 0);
    check_eq("rst_dout", 32'(data_out), 0);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("run_ce1_n", 32'(sram1_ce_n), 0);
    check_eq("run_lb1_n", 32'(sram1_lb_n), 0);

    do_write(15'o00200, 12'o7402, 4);
    check_eq("mem_00200", mem[15'o00200], 'h0F02);
    do_read(15'o00200, 12'o7402, "rd_00200");

    do_write(15'o00000, 12'o5555, 2);
    @(negedge clk);
    addr = 15'o77777;
    #1;
    check_eq("sram_a_top", 32'(sram_a), 'h07FFF);
    do_write(15'o77777, 12'o1234, 3);
    check_eq("mem_77777", mem[15'o77777], 'h029C);
    do_read(15'o77777, 12'o1234, "rd_77777");
    do_read(15'o00000, 12'o5555, "rd_00000");
    check_eq("mem_00000", mem[15'o00000], 'h0B6D);
    @(negedge clk);
    addr = 15'o00200;
    #1;
    check_eq("hold_addr_chg", 32'(data_out), 'o5555);

    // rd and wr together: write wins, no output enable.
    @(negedge clk);
    p0 = pulse_cnt;
    addr = 15'o00010; data_in = 12'o0042; rd = 1'b1; wr = 1'b1;
    #1;
    check_eq("both_oe_n", 32'(sram_oe_n), 1);
    repeat (3) @(negedge clk);
    check_eq("both_oe_n_hold", 32'(sram_oe_n), 1);
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    check_eq("both_pulses", pulse_cnt - p0, 1);
    check_eq("mem_00010", mem[15'o00010], 'h0022);

    // Reset in the middle of a write pulse.
    @(negedge clk);
    addr = 15'o00300; data_in = 12'o7777; wr = 1'b1;
    @(posedge clk);
    #1;
    check_eq("wpulse_we_n", 32'(sram_we_n), 0);
    check_eq("wpulse_drive", 32'(dut.drive_q), 1);
    reset = 1'b0;
    #1;
    check_eq("int_we_n", 32'(sram_we_n), 1);
    check_eq("int_drive", 32'(dut.drive_q), 0);
    check_eq("int_dout", 32'(data_out), 0);
    check_eq("int_oe_n", 32'(sram_oe_n), 1);
    check_eq("int_ce1_n", 32'(sram1_ce_n), 1);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    p0 = pulse_cnt;
    repeat (2) @(negedge clk);
    check_eq("post_rst_pulses", pulse_cnt - p0, 0);
    do_read(15'o00200, 12'o7402, "rd_after_rst");

    check_eq("sram2_parked", sram2_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
